sdpram_be: RTL and testbench
============================

Name: sdpram_be

Overview:
- Single-clock simple dual-port RAM: one write port, one read port.
- Next generation of the team's dual-port RAM. Adds per-byte write enables, selectable read latency, defined read-during-write behaviour, a read-valid strobe and a post-reset hardware clear sequence.
- Used as the storage core for synchronous FIFOs and buffers inside a single clock domain.

Parameters:
- WIDTH, 32, data word width; must be a multiple of BYTE_W.
- DEPTH, 16, number of words; need not be a power of 2.
- ADDR, 4, address width; must satisfy 2**ADDR >= DEPTH.
- BYTE_W, 8, bits per write-enable lane; NB = WIDTH/BYTE_W.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new data (bypass).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- wr_be  in  NB  byte-lane write enables; bit i covers wr_data[i*BYTE_W +: BYTE_W].
- wr_addr  in  ADDR  write address.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR  read address.
- rd_data  out  WIDTH  read data; holds its value between reads.
- rd_valid  out  1  one-cycle strobe, aligned with new rd_data.
- init_done  out  1  high once the clear sequence completes.
- rd_perr  out  NB  per-byte parity error, aligned with rd_valid (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous): rd_data=0, rd_valid=0, rd_perr=0, init_done=0, pipeline registers=0, FSM=CLEAR, clear counter=0. Array contents are not reset directly.
- FSM CLEAR:
  - Each cycle writes all-zero (and parity 0) to address clr_cnt, then clr_cnt++.
  - After writing address DEPTH-1, moves to RUN.
  - init_done rises at the edge ending the DEPTH-th clear cycle.
- FSM RUN: terminal state; only reset leaves it.
- Any rst_n assertion mid-operation, including mid-clear, restarts CLEAR from address 0.
- While init_done=0, wr_en and rd_en are ignored. Nothing is queued; rd_valid stays 0.
- Write (RUN, wr_en=1, wr_addr<DEPTH): byte lanes with wr_be[i]=1 update at the clk edge; other lanes keep their contents. wr_be=0 is a no-op.
- Read (RUN, rd_en=1, rd_addr<DEPTH):
  - RD_LAT=1: rd_data updates and rd_valid=1 at the first edge after the request.
  - RD_LAT=2: both appear one edge later.
  - Fully pipelined: back-to-back reads give back-to-back rd_valid.
  - rd_data is not cleared after a read; it holds until the next valid read.
- Out of range (addr >= DEPTH):
  - Write: dropped.
  - Read: rd_data=0 with rd_valid=1 at normal latency.
- Read and write to the same address in the same cycle:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word, i.e. new bytes where wr_be=1 and old bytes elsewhere.
- Read and write to different addresses in the same cycle: independent, no stall.

Optional Feature:
- Macro: SDPRAM_PARITY_EN.
- Defined:
  - Array stores NB extra even-parity bits, one per byte, computed on the write path.
  - Each read recomputes parity. rd_perr[i]=1 when byte i mismatches, aligned with rd_valid; 0 otherwise.
  - Out-of-range reads return rd_perr=0.
- Undefined: no parity storage; rd_perr is tied to 0. The port list is identical in both builds.

Decomposition:
- Package sdpram_pkg:
  - State enum {CLEAR, RUN}.
  - RDW_OLD=0 and RDW_NEW=1 constants.
  - Function byte_parity(data, NB) returning an NB-bit vector.
  - Elaboration-time check functions for the WIDTH % BYTE_W, 2**ADDR >= DEPTH and RD_LAT parameter rules.
- One sub-module: sdpram_rd_pipe. It carries the data/valid/perr output register stage(s) for RD_LAT 1 or 2. The top holds the array, byte-enable write, RDW mux and clear FSM.

Test Plan:
- Release reset with DEPTH=16 -> init_done=0 for 16 cycles, then 1. Reads of all 16 addresses return 0x00000000 with no rd_perr.
- Write 0xAABBCCDD @3 with be=4'b1111, then 0x11223344 @3 with be=4'b0101 -> read @3 returns 0xAA22CC44.
- RD_LAT=2, rd_en on 4 consecutive cycles, addr 0..3 -> rd_valid high for 4 consecutive cycles starting 2 edges after the first request; data in order.
- Same-cycle write 0xDEADBEEF be=4'b1100 and read @5 (old 0x12345678):
  - RDW_MODE=0 -> 0x12345678.
  - RDW_MODE=1 -> 0xDEAD5678.
- Assert rst_n low 5 cycles into CLEAR, and wr_en/rd_en during CLEAR -> FSM restarts; no write lands; rd_valid stays 0; init_done rises 16 cycles after release.
- SDPRAM_PARITY_EN, DEPTH=12: force-flip bit 9 of stored word @2 -> read @2 gives rd_perr=4'b0010. Read @13 -> rd_data=0, rd_valid=1, rd_perr=0.

Source files
------------

// File: rtl/sdpram_pkg.sv
// sdpram_pkg -- shared types, constants and helpers for sdpram_be.
//   state_t        : clear-sequence FSM states (CLEAR, RUN)
//   RDW_OLD/RDW_NEW: same-address read-during-write selection
//   byte_parity    : per-byte even-parity vector of a data word
//   *_ok functions : elaboration-time parameter legality checks
package sdpram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Upper bounds for the width-generic parity helper; callers cast in/out.
  localparam int MAX_W  = 1024;
  localparam int MAX_NB = 128;

  // Bit i is the XOR of byte i, so byte plus parity bit has even weight.
  function automatic logic [MAX_NB-1:0] byte_parity(input logic [MAX_W-1:0] data,
                                                    input int nb, input int byte_w);
    logic [MAX_NB-1:0] p;
    p = '0;
    for (int i = 0; i < nb; i++) begin
      for (int b = 0; b < byte_w; b++) begin
        p[i] = p[i] ^ data[i*byte_w + b];
      end
    end
    return p;
  endfunction

  function automatic bit width_ok(input int w, input int bw);
    return (bw > 0) && (w > 0) && ((w % bw) == 0);
  endfunction

  function automatic bit depth_ok(input int d, input int a);
    return (d > 0) && (a > 0) && (a < 31) && ((1 << a) >= d);
  endfunction

  function automatic bit rd_lat_ok(input int l);
    return (l == 1) || (l == 2);
  endfunction

endpackage

// File: rtl/sdpram_rd_pipe.sv
// sdpram_rd_pipe -- read output register stage(s) for sdpram_be.
//   i_valid/i_data/i_perr : read result from the array side (request cycle)
//   o_valid               : one-cycle strobe, RD_LAT edges after i_valid
//   o_data                : read word; holds between valid reads
//   o_perr                : parity flags while o_valid, else 0
// RD_LAT=2 adds one plain pipeline stage in front of the output register.
module sdpram_rd_pipe #(
  parameter int WIDTH  = 32,
  parameter int NB     = 4,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic [NB-1:0]    i_perr,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [NB-1:0]    o_perr
);

  logic             w_valid;
  logic [WIDTH-1:0] w_data;
  logic [NB-1:0]    w_perr;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [NB-1:0]    r_perr;

  if (RD_LAT == 2) begin : g_lat2
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic [NB-1:0]    r_s1_perr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1_valid <= 1'b0;
        r_s1_data  <= '0;
        r_s1_perr  <= '0;
      end else begin
        r_s1_valid <= i_valid;
        r_s1_data  <= i_data;
        r_s1_perr  <= i_perr;
      end
    end

    assign w_valid = r_s1_valid;
    assign w_data  = r_s1_data;
    assign w_perr  = r_s1_perr;
  end else begin : g_lat1
    assign w_valid = i_valid;
    assign w_data  = i_data;
    assign w_perr  = i_perr;
  end

  // Data only moves on a valid read so the last result stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_perr  <= '0;
    end else begin
      r_valid <= w_valid;
      if (w_valid) begin
        r_data <= w_data;
      end
      r_perr <= w_valid ? w_perr : '0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_perr  = r_perr;

endmodule

// File: rtl/sdpram_be.sv
// sdpram_be -- single-clock simple dual-port RAM with byte enables.
//   clk, rst_n         : clock (rising edge), async active-low reset
//   wr_en/wr_be/wr_addr/wr_data : write port, per-byte lane enables
//   rd_en/rd_addr      : read request
//   rd_data/rd_valid   : read result after RD_LAT edges; data holds
//   init_done          : high once every word has been cleared after reset
//   rd_perr            : per-byte parity error, aligned with rd_valid
// Optional macro SDPRAM_PARITY_EN: stores one even-parity bit per byte and
// checks it on read; without it rd_perr is constant 0.
// After reset the FSM spends DEPTH cycles in CLEAR writing zeros, then sits
// in RUN; user requests are ignored until RUN.
module sdpram_be
  import sdpram_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR     = 4,
  parameter int BYTE_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0,
  localparam int NB      = WIDTH / BYTE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [NB-1:0]    wr_be,
  input  logic [ADDR-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [ADDR-1:0]  rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             init_done,
  output logic [NB-1:0]    rd_perr
);

  if (!width_ok(WIDTH, BYTE_W)) begin : g_bad_width
    $error("sdpram_be: WIDTH must be a non-zero multiple of BYTE_W");
  end
  if (!depth_ok(DEPTH, ADDR)) begin : g_bad_depth
    $error("sdpram_be: 2**ADDR must be >= DEPTH");
  end
  if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
    $error("sdpram_be: RD_LAT must be 1 or 2");
  end

  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

  state_t           r_state;
  logic [ADDR-1:0]  r_clr_cnt;
  logic             r_init_done;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_run;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_wr_fire;
  logic             w_rd_fire;
  logic             w_same;
  logic [WIDTH-1:0] w_rd_word;
  logic [NB-1:0]    w_rd_perr;

  assign w_run     = (r_state == RUN);
  assign w_wr_ok   = (int'(wr_addr) < DEPTH);
  assign w_rd_ok   = (int'(rd_addr) < DEPTH);
  assign w_wr_fire = w_run && wr_en && w_wr_ok;
  // Out-of-range reads still return a (zero) result at normal latency.
  assign w_rd_fire = w_run && rd_en;
  assign w_same    = w_wr_fire && (wr_addr == rd_addr);

  // Clear sequence FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= CLEAR;
      r_clr_cnt   <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == LAST_ADDR) begin
            r_state     <= RUN;
            r_init_done <= 1'b1;
          end
        end
        RUN:     r_state <= RUN;
        default: r_state <= CLEAR;
      endcase
    end
  end

`ifdef SDPRAM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_wr_par;
  logic [NB-1:0] w_rd_par;

  assign w_wr_par = NB'(byte_parity(MAX_W'(wr_data), NB, BYTE_W));
`endif

  // Storage: clear writes take priority; user writes only happen in RUN.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_clr_cnt] <= '0;
`ifdef SDPRAM_PARITY_EN
      r_par[r_clr_cnt] <= '0;
`endif
    end else if (w_wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          r_mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
`ifdef SDPRAM_PARITY_EN
          r_par[wr_addr][i] <= w_wr_par[i];
`endif
        end
      end
    end
  end

  // Read word; with RDW_NEW the enabled lanes of a same-address write bypass.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_ok) begin
      w_rd_word = r_mem[rd_addr];
      if ((RDW_MODE == RDW_NEW) && w_same) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_be[i]) begin
            w_rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end

`ifdef SDPRAM_PARITY_EN
  always_comb begin
    w_rd_par = '0;
    if (w_rd_ok) begin
      w_rd_par = r_par[rd_addr];
      if ((RDW_MODE == RDW_NEW) && w_same) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_be[i]) begin
            w_rd_par[i] = w_wr_par[i];
          end
        end
      end
    end
    w_rd_perr = '0;
    if (w_rd_ok) begin
      w_rd_perr = NB'(byte_parity(MAX_W'(w_rd_word), NB, BYTE_W)) ^ w_rd_par;
    end
  end
`else
  assign w_rd_perr = '0;
`endif

  sdpram_rd_pipe #(
    .WIDTH  (WIDTH),
    .NB     (NB),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_rd_fire),
    .i_data  (w_rd_word),
    .i_perr  (w_rd_perr),
    .o_valid (rd_valid),
    .o_data  (rd_data),
    .o_perr  (rd_perr)
  );

  assign init_done = r_init_done;

endmodule

// File: tb/tb_sdpram_be.sv
// tb_sdpram_be -- bench for sdpram_be. Two instances share one stimulus:
//   dut0: DEPTH=16, RD_LAT=1, RDW_MODE=0 (old data)
//   dut1: DEPTH=12, RD_LAT=2, RDW_MODE=1 (new data), so 12..15 are out of range
// Each read pushes {expected cycle, perr, data} per instance; a negedge
// monitor pops and compares when rd_valid appears.
module tb_sdpram_be;

  localparam int WIDTH  = 32;
  localparam int ADDR   = 4;
  localparam int NB     = 4;
  localparam int DEPTH0 = 16;
  localparam int DEPTH1 = 12;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [NB-1:0]     wr_be;
  logic [ADDR-1:0]   wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_en;
  logic [ADDR-1:0]   rd_addr;
  logic [WIDTH-1:0]  rd_data_a  [2];
  logic              rd_valid_a [2];
  logic              init_done_a[2];
  logic [NB-1:0]     rd_perr_a  [2];

  int checks;
  int failures;
  int cyc;

  logic [51:0]      exp_q [2][$];
  logic [WIDTH-1:0] last_a [2];
  logic [WIDTH-1:0] mdl0 [16];
  logic [WIDTH-1:0] mdl1 [16];
  logic [NB-1:0]    pmdl0 [16];
  logic [NB-1:0]    pmdl1 [16];

  sdpram_be #(.WIDTH(WIDTH), .DEPTH(DEPTH0), .ADDR(ADDR), .BYTE_W(8),
              .RD_LAT(1), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a[0]),
    .rd_valid(rd_valid_a[0]), .init_done(init_done_a[0]), .rd_perr(rd_perr_a[0]));

  sdpram_be #(.WIDTH(WIDTH), .DEPTH(DEPTH1), .ADDR(ADDR), .BYTE_W(8),
              .RD_LAT(2), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a[1]),
    .rd_valid(rd_valid_a[1]), .init_done(init_done_a[1]), .rd_perr(rd_perr_a[1]));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit we, input logic [3:0] be, input int wa,
                       input logic [31:0] wd, input bit re, input int ra);
    logic [31:0] e0, e1;
    logic [3:0]  p0, p1;
    @(posedge clk); #1;
    wr_en   = we;
    wr_be   = be;
    wr_addr = wa[3:0];
    wr_data = wd;
    rd_en   = re;
    rd_addr = ra[3:0];
    if (re) begin
      e0 = (ra < DEPTH0) ? mdl0[ra]  : 32'h0;
      p0 = (ra < DEPTH0) ? pmdl0[ra] : 4'h0;
      e1 = (ra < DEPTH1) ? mdl1[ra]  : 32'h0;
      p1 = (ra < DEPTH1) ? pmdl1[ra] : 4'h0;
      if (we && (wa == ra) && (ra < DEPTH1)) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) begin
            e1[i*8 +: 8] = wd[i*8 +: 8];
            p1[i] = 1'b0;
          end
        end
      end
      exp_q[0].push_back({16'(cyc + 1), p0, e0});
      exp_q[1].push_back({16'(cyc + 2), p1, e1});
    end
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          if (wa < DEPTH0) begin
            mdl0[wa][i*8 +: 8] = wd[i*8 +: 8];
            pmdl0[wa][i] = 1'b0;
          end
          if (wa < DEPTH1) begin
            mdl1[wa][i*8 +: 8] = wd[i*8 +: 8];
            pmdl1[wa][i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 4'h0, 0, 32'h0, 1'b0, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (((exp_q[0].size() != 0) || (exp_q[1].size() != 0)) && (k < 20)) begin
      @(negedge clk);
      k++;
    end
    check("drain_q0", 64'(exp_q[0].size()), 64'd0);
    check("drain_q1", 64'(exp_q[1].size()), 64'd0);
  endtask

  // Release reset; optionally poke writes/reads during CLEAR; measure init.
  task automatic release_and_wait(input bit poke);
    int rel, got0, got1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rel = cyc;
    for (int a = 0; a < 16; a++) begin
      mdl0[a] = '0; mdl1[a] = '0; pmdl0[a] = '0; pmdl1[a] = '0;
    end
    got0 = -1;
    got1 = -1;
    for (int k = 0; (k < 64) && ((got0 < 0) || (got1 < 0)); k++) begin
      @(negedge clk);
      if (init_done_a[0] && (got0 < 0)) got0 = cyc - rel;
      if (init_done_a[1] && (got1 < 0)) got1 = cyc - rel;
      if (poke && (k < 8)) begin
        wr_en = 1'b1; wr_be = 4'hF; wr_addr = 4'd0; wr_data = 32'hCAFEF00D;
        rd_en = 1'b1; rd_addr = 4'd0;
      end else begin
        wr_en = 1'b0; rd_en = 1'b0;
      end
    end
    check("init_lat_d0", 64'(got0), 64'(DEPTH0));
    check("init_lat_d1", 64'(got1), 64'(DEPTH1));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [51:0] e;
    if (!rst_n) begin
      last_a[0] = '0;
      last_a[1] = '0;
      exp_q[0].delete();
      exp_q[1].delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (rd_valid_a[d]) begin
          if (exp_q[d].size() == 0) begin
            check($sformatf("d%0d_unexp_valid", d), 64'd1, 64'd0);
          end else begin
            e = exp_q[d].pop_front();
            check($sformatf("d%0d_data", d), 64'(rd_data_a[d]), 64'(e[31:0]));
            check($sformatf("d%0d_perr", d), 64'(rd_perr_a[d]), 64'(e[35:32]));
            check($sformatf("d%0d_lat", d), 64'(cyc), 64'(e[51:36]));
            last_a[d] = e[31:0];
          end
        end else begin
          check($sformatf("d%0d_hold", d), 64'(rd_data_a[d]), 64'(last_a[d]));
          check($sformatf("d%0d_perr_idle", d), 64'(rd_perr_a[d]), 64'd0);
          if ((exp_q[d].size() != 0) && (int'(exp_q[d][0][51:36]) < cyc)) begin
            check($sformatf("d%0d_missed_valid", d), 64'd0, 64'd1);
            e = exp_q[d].pop_front();
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    wr_en = 1'b0; wr_be = '0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rst_data", d), 64'(rd_data_a[d]), 64'd0);
      check($sformatf("d%0d_rst_valid", d), 64'(rd_valid_a[d]), 64'd0);
      check($sformatf("d%0d_rst_init", d), 64'(init_done_a[d]), 64'd0);
      check($sformatf("d%0d_rst_perr", d), 64'(rd_perr_a[d]), 64'd0);
    end

    release_and_wait(1'b0);

    // Cleared contents, back-to-back reads of every address.
    for (int a = 0; a < 16; a++) drive(1'b0, 4'h0, 0, 32'h0, 1'b1, a);
    idle(1);

    // Byte-enable merge.
    drive(1'b1, 4'b1111, 3, 32'hAABBCCDD, 1'b0, 0);
    drive(1'b1, 4'b0101, 3, 32'h11223344, 1'b0, 0);
    drive(1'b0, 4'h0, 0, 32'h0, 1'b1, 3);
    idle(1);

    // Pipelined reads 0..3.
    for (int a = 0; a < 3; a++) drive(1'b1, 4'hF, a, 32'h10000000 + a, 1'b0, 0);
    drive(1'b1, 4'hF, 5, 32'h12345678, 1'b0, 0);
    for (int a = 0; a < 4; a++) drive(1'b0, 4'h0, 0, 32'h0, 1'b1, a);
    idle(1);

    // Same-address read-during-write, then read back the merged word.
    drive(1'b1, 4'b1100, 5, 32'hDEADBEEF, 1'b1, 5);
    drive(1'b0, 4'h0, 0, 32'h0, 1'b1, 5);
    // Different addresses in the same cycle.
    drive(1'b1, 4'hF, 7, 32'h0BADF00D, 1'b1, 5);
    drive(1'b0, 4'h0, 0, 32'h0, 1'b1, 7);
    // wr_be=0 is a no-op.
    drive(1'b1, 4'h0, 5, 32'hFFFFFFFF, 1'b0, 0);
    drive(1'b0, 4'h0, 0, 32'h0, 1'b1, 5);
    // Address 13: in range for dut0, out of range (dropped / zero) for dut1.
    drive(1'b1, 4'hF, 13, 32'h55AA55AA, 1'b0, 0);
    drive(1'b0, 4'h0, 0, 32'h0, 1'b1, 13);
    idle(1);

    // Random traffic with forced collisions.
    for (int k = 0; k < 80; k++) begin
      bit we, re;
      int wa, ra;
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wa = $urandom_range(0, 15);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
      drive(we, 4'($urandom_range(0, 15)), wa, $urandom, re, ra);
    end
    idle(1);
    drain();

`ifdef SDPRAM_PARITY_EN
    // Corrupt one stored bit (byte 1) behind the parity bit's back.
    drive(1'b1, 4'hF, 2, 32'h00000000, 1'b0, 0);
    idle(1);
    @(negedge clk);
    dut0.r_mem[2][9] <= ~dut0.r_mem[2][9];
    dut1.r_mem[2][9] <= ~dut1.r_mem[2][9];
    mdl0[2] = mdl0[2] ^ 32'h00000200;
    mdl1[2] = mdl1[2] ^ 32'h00000200;
    pmdl0[2] = 4'b0010;
    pmdl1[2] = 4'b0010;
    drive(1'b0, 4'h0, 0, 32'h0, 1'b1, 2);
    drive(1'b0, 4'h0, 0, 32'h0, 1'b1, 13);
    idle(1);
    drain();
`endif

    // Reset 5 cycles into CLEAR, then poke the ports during the new CLEAR.
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("midclr_init_d0", 64'(init_done_a[0]), 64'd0);
    check("midclr_init_d1", 64'(init_done_a[1]), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    release_and_wait(1'b1);
    drive(1'b0, 4'h0, 0, 32'h0, 1'b1, 0);
    drive(1'b0, 4'h0, 0, 32'h0, 1'b1, 3);
    drive(1'b0, 4'h0, 0, 32'h0, 1'b1, 5);
    idle(2);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
